nibble_add_seq: RTL and testbench

//  Multi-cycle controller that adds two WIDTH-bit operands with one shared
//  4-bit adder slice (adder_4bit: a, b, cin -> sum, cout), one nibble per

---
 rtl/nibble_add_seq_if.sv | 29 ++
 rtl/nibble_add_seq.sv | 105 ++++++++++
 tb/tb_nibble_add_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_if.sv
// Requester and adder-slice signal bundle for nibble_add_seq.
// slave is the controller's view; master is the requester/adder side.
interface nibble_add_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    modport master (
        output start, op_a, op_b, op_cin, add_sum, add_cout,
        input  busy, done, result, cout, add_a, add_b, add_cin
    );

    modport slave (
        input  start, op_a, op_b, op_cin, add_sum, add_cout,
        output busy, done, result, cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/nibble_add_seq.sv
// Sequential WIDTH-bit adder: drives one external 4-bit adder slice a nibble
// per clock, LSB first, with the carry registered between nibbles.
module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    nibble_add_seq_if.slave  bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_sh_a;
    logic [WIDTH-1:0]  r_sh_b;
    logic [WIDTH-5:0]  r_acc;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_result;
    logic              r_cout;
    logic              w_last;
    logic [WIDTH-1:0]  w_acc_cat;

    // Only the upper WIDTH-4 accumulator bits are ever observed, so just those
    // are stored; the concatenation is the full shifted accumulator.
    assign w_acc_cat = {bus.add_sum, r_acc};
    assign w_last    = (r_idx == IDXW'(NIB - 1));

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
    assign bus.cout   = r_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RUN;
            end
            S_RUN: begin
                bus.add_a   = r_sh_a[3:0];
                bus.add_b   = r_sh_b[3:0];
                bus.add_cin = r_carry;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sh_a  <= bus.op_a;
                        r_sh_b  <= bus.op_b;
                        r_carry <= bus.op_cin;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_cat[WIDTH-1:4];
                    r_carry <= bus.add_cout;
                    r_sh_a  <= r_sh_a >> 4;
                    r_sh_b  <= r_sh_b >> 4;
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_result <= w_acc_cat;
                        r_cout   <= bus.add_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq (WIDTH=16) with a behavioural 4-bit adder slice.
module tb_nibble_add_seq;
    logic clk;
    logic rst;
    int   errs   = 0;
    int   checks = 0;
    logic [16:0] last_exp;

    nibble_add_seq_if #(.WIDTH(16)) bus ();

    nibble_add_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign {bus.add_cout, bus.add_sum} = bus.add_a + bus.add_b + {4'd0, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full add with per-nibble slice expectations derived from plain arithmetic.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic c);
        logic [16:0] exp;
        int unsigned edges;
        int unsigned busyc;
        int unsigned i;
        logic [31:0] m;
        logic [31:0] cin_i;
        exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
        bus.start  = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.op_cin = c;
        tick();
        bus.start = 1'b0;
        edges = 1;
        busyc = 0;
        chk({name, " held"}, {15'd0, bus.cout, bus.result}, {15'd0, last_exp});
        while (!bus.done && edges < 20) begin
            if (bus.busy) busyc++;
            i = edges - 1;
            if (i < 4) begin
                m     = (32'd1 << (4 * i)) - 32'd1;
                cin_i = ((({16'd0, a} & m) + ({16'd0, b} & m) + {31'd0, c}) >> (4 * i)) & 32'd1;
                chk({name, " add_a"}, {28'd0, bus.add_a}, ({16'd0, a} >> (4 * i)) & 32'hF);
                chk({name, " add_b"}, {28'd0, bus.add_b}, ({16'd0, b} >> (4 * i)) & 32'hF);
                chk({name, " add_cin"}, {31'd0, bus.add_cin}, cin_i);
            end
            bus.op_a   = 16'($urandom);
            bus.op_b   = 16'($urandom);
            bus.op_cin = 1'($urandom);
            tick();
            edges++;
        end
        if (bus.busy) busyc++;
        chk({name, " done"}, {31'd0, bus.done}, 32'd1);
        chk({name, " latency"}, edges, 32'd5);
        chk({name, " busy_cycles"}, busyc, 32'd5);
        chk({name, " sum"}, {15'd0, bus.cout, bus.result}, {15'd0, exp});
        last_exp = exp;
        tick();
        chk({name, " done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({name, " idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int unsigned edges;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.op_cin = 1'b0;
        last_exp   = '0;
        tick();
        tick();
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst result", {15'd0, bus.cout, bus.result}, 32'd0);
        chk("rst add", {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("T1", 16'h00FF, 16'h0001, 1'b0);
        run_op("T2", 16'hFFFF, 16'h0000, 1'b1);
        run_op("T3", 16'hC3A5, 16'h5A3C, 1'b0);

        // T4: start held high throughout; op_a churns while busy
        bus.start  = 1'b1;
        bus.op_a   = 16'h1234;
        bus.op_b   = 16'h4321;
        bus.op_cin = 1'b0;
        tick();
        edges = 1;
        while (!bus.done && edges < 20) begin
            bus.op_a = 16'($urandom);
            tick();
            edges++;
        end
        chk("T4 done", {31'd0, bus.done}, 32'd1);
        chk("T4 sum1", {15'd0, bus.cout, bus.result}, 32'h05555);
        bus.op_a = 16'($urandom);
        tick();
        chk("T4 idle", {31'd0, bus.busy}, 32'd0);
        bus.op_a = 16'h8000;
        bus.op_b = 16'h8001;
        tick();
        chk("T4 accept", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        edges = 1;
        while (!bus.done && edges < 20) begin
            tick();
            edges++;
        end
        chk("T4 done2", {31'd0, bus.done}, 32'd1);
        chk("T4 sum2", {15'd0, bus.cout, bus.result}, 32'h10001);
        tick();

        // T5: async reset in the 2nd RUN cycle
        bus.start  = 1'b1;
        bus.op_a   = 16'hABCD;
        bus.op_b   = 16'h1111;
        bus.op_cin = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("T5 running", {31'd0, bus.busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("T5 busy", {31'd0, bus.busy}, 32'd0);
        chk("T5 done", {31'd0, bus.done}, 32'd0);
        chk("T5 result", {15'd0, bus.cout, bus.result}, 32'd0);
        chk("T5 add", {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
        tick();
        rst = 1'b0;
        last_exp = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("T5 no_done", {31'd0, bus.done}, 32'd0);
        end
        run_op("T5 post", 16'h0001, 16'h0001, 1'b0);

        for (int n = 0; n < 200; n++) begin
            run_op("T6", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
